pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Detects load-use hazards that the ID-stage forwarding paths cannot cover.
- Holds the pipeline while the data bus is busy, with a timeout.
- Applies branch/jump redirects from EX and generates per-register stall/flush vectors.
- Keeps 32-bit stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/pipe_ctrl_hazard_det.sv | 32 +++
 rtl/pipe_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
// Stall/flush vector bit indices, FSM state encoding, neutral stall/flush
// constants and the core-wide reset/word/register-address constants.
package pipe_ctrl_pkg;

    // Core-wide constants
    localparam logic        RstEnable  = 1'b1;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam int unsigned RegAddrBus = 5;

    // Bit positions inside stall/flush vectors
    localparam int unsigned STALL_PC    = 0;
    localparam int unsigned STALL_IFID  = 1;
    localparam int unsigned STALL_IDEX  = 2;
    localparam int unsigned STALL_EXMEM = 3;
    localparam int unsigned STALL_MEMWB = 4;

    localparam logic [4:0] NoStall  = 5'b00000;
    localparam logic [4:0] NoFlush  = 5'b00000;
    localparam logic [4:0] AllFlush = 5'b11111;

    // Bus hold: freeze PC..EX/MEM, bubble into WB
    localparam logic [4:0] MemHoldStall = 5'b01111;
    localparam logic [4:0] MemHoldFlush = 5'b10000;
    // Load-use: freeze PC and IF/ID, bubble into EX
    localparam logic [4:0] LuStall      = 5'b00011;
    localparam logic [4:0] LuFlush      = 5'b00100;
    // Redirect: squash the IF and ID instructions
    localparam logic [4:0] JumpFlush    = 5'b00110;

    typedef enum logic [0:0] {
        StRun     = 1'b0,
        StMemWait = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   id_reg1_re/id_reg1_raddr  rs1 read enable/address in ID
//   id_reg2_re/id_reg2_raddr  rs2 read enable/address in ID
//   ex_is_load/ex_we/ex_waddr load flag, write enable and rd of EX
//   lu                        hazard: ID needs a value the EX load has not produced
module pipe_ctrl_hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic                  id_reg1_re,
    input  logic [RegAddrBus-1:0] id_reg1_raddr,
    input  logic                  id_reg2_re,
    input  logic [RegAddrBus-1:0] id_reg2_raddr,
    input  logic                  ex_is_load,
    input  logic                  ex_we,
    input  logic [RegAddrBus-1:0] ex_waddr,
    output logic                  lu
);

    logic ex_load_wr;
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        // x0 writes are discarded, so they never create a dependency
        ex_load_wr = ex_is_load & ex_we & (ex_waddr != '0);
        rs1_hit    = id_reg1_re & (id_reg1_raddr == ex_waddr);
        rs2_hit    = id_reg2_re & (id_reg2_raddr == ex_waddr);
        lu         = ex_load_wr & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage RV32I core.
// Ports:
//   clk, rst                  core clock, async active-high reset
//   id_reg*_re/raddr          ID-stage register reads
//   ex_is_load/ex_we/ex_waddr EX-stage destination info
//   ex_jump/ex_jump_addr      taken branch/jump and its target from EX
//   mem_req/mem_ack           MEM-stage bus request and completion
//   stall/flush               per-register hold enables and bubble inserts
//   redirect/redirect_pc      PC reload request and target
//   bus_err                   one-cycle pulse after a bus timeout
//   stall_cnt/flush_cnt       performance counters (PC stall cycles, redirects)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_reg1_re,
    input  logic [RegAddrBus-1:0] id_reg1_raddr,
    input  logic                  id_reg2_re,
    input  logic [RegAddrBus-1:0] id_reg2_raddr,
    input  logic                  ex_is_load,
    input  logic                  ex_we,
    input  logic [RegAddrBus-1:0] ex_waddr,
    input  logic                  ex_jump,
    input  logic [31:0]           ex_jump_addr,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic [4:0]            stall,
    output logic [4:0]            flush,
    output logic                  redirect,
    output logic [31:0]           redirect_pc,
    output logic                  bus_err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned WaitW = 16;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    pipe_state_e      state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;

    logic       lu;
    logic       mb;
    logic       run_eval;
    logic       timeout;
    logic [4:0] stall_c;
    logic [4:0] flush_c;
    logic       redirect_c;

    pipe_ctrl_hazard_det u_hazard_det (
        .id_reg1_re    (id_reg1_re),
        .id_reg1_raddr (id_reg1_raddr),
        .id_reg2_re    (id_reg2_re),
        .id_reg2_raddr (id_reg2_raddr),
        .ex_is_load    (ex_is_load),
        .ex_we         (ex_we),
        .ex_waddr      (ex_waddr),
        .lu            (lu)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        stall_c    = NoStall;
        flush_c    = NoFlush;
        redirect_c = 1'b0;
        run_eval   = 1'b0;
        timeout    = 1'b0;
        mb         = mem_req & ~mem_ack;

        unique case (state_q)
            StRun: begin
                if (mb) begin
                    stall_c = MemHoldStall;
                    flush_c = MemHoldFlush;
                    state_d = StMemWait;
                    wait_d  = WaitW'(1);
                end else begin
                    run_eval = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_ack) begin
                    // Ack cycle releases the hold and evaluates jump/lu as in RUN
                    run_eval = 1'b1;
                    state_d  = StRun;
                    wait_d   = '0;
                end else if (!mem_req) begin
                    // MEM was flushed underneath us; hold once more, then resume
                    stall_c = MemHoldStall;
                    flush_c = MemHoldFlush;
                    state_d = StRun;
                    wait_d  = '0;
                end else if (wait_q == WaitLast) begin
                    // Drop the faulting access: release everything, bubble WB
                    flush_c = MemHoldFlush;
                    timeout = 1'b1;
                    state_d = StRun;
                    wait_d  = '0;
                end else begin
                    stall_c = MemHoldStall;
                    flush_c = MemHoldFlush;
                    wait_d  = wait_q + WaitW'(1);
                end
            end
            default: begin
                state_d = StRun;
                wait_d  = '0;
            end
        endcase

        if (run_eval) begin
            // Jump wins over lu: the dependent ID instruction is squashed anyway
            if (ex_jump) begin
                redirect_c = 1'b1;
                flush_c    = JumpFlush;
            end else if (lu) begin
                stall_c = LuStall;
                flush_c = LuFlush;
            end
        end
    end

    always_comb begin
        stall       = (rst == RstEnable) ? NoStall : stall_c;
        flush       = (rst == RstEnable) ? AllFlush : flush_c;
        redirect    = (rst == RstEnable) ? 1'b0 : redirect_c;
        redirect_pc = redirect ? ex_jump_addr : ZeroWord;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q   <= StRun;
            wait_q    <= '0;
            bus_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            bus_err <= timeout;
            if (stall[STALL_PC]) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a scoreboard of expected combinational
// outputs and a small model of the registered counters and bus_err.
module tb_pipe_ctrl;

    typedef struct packed {
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        redirect;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_reg1_re = 1'b0;
    logic [4:0]  id_reg1_raddr = '0;
    logic        id_reg2_re = 1'b0;
    logic [4:0]  id_reg2_raddr = '0;
    logic        ex_is_load = 1'b0;
    logic        ex_we = 1'b0;
    logic [4:0]  ex_waddr = '0;
    logic        ex_jump = 1'b0;
    logic [31:0] ex_jump_addr = '0;
    logic        mem_req = 1'b0;
    logic        mem_ack = 1'b0;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        bus_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    pipe_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_reg1_re    (id_reg1_re),
        .id_reg1_raddr (id_reg1_raddr),
        .id_reg2_re    (id_reg2_re),
        .id_reg2_raddr (id_reg2_raddr),
        .ex_is_load    (ex_is_load),
        .ex_we         (ex_we),
        .ex_waddr      (ex_waddr),
        .ex_jump       (ex_jump),
        .ex_jump_addr  (ex_jump_addr),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .stall         (stall),
        .flush         (flush),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .bus_err       (bus_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_reg1_re    = 1'b0;
        id_reg1_raddr = '0;
        id_reg2_re    = 1'b0;
        id_reg2_raddr = '0;
        ex_is_load    = 1'b0;
        ex_we         = 1'b0;
        ex_waddr      = '0;
        ex_jump       = 1'b0;
        ex_jump_addr  = '0;
        mem_req       = 1'b0;
        mem_ack       = 1'b0;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step(input string tag, input logic [4:0] e_stall, input logic [4:0] e_flush,
                        input logic e_redir, input logic [31:0] e_pc, input logic e_berr);
        exp_t e;
        exp_t got;
        e.stall    = e_stall;
        e.flush    = e_flush;
        e.redirect = e_redir;
        e.pc       = e_pc;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, ".stall"}, {27'd0, stall}, {27'd0, got.stall});
            chk({tag, ".flush"}, {27'd0, flush}, {27'd0, got.flush});
            chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, got.redirect});
            if (got.redirect) begin
                chk({tag, ".redirect_pc"}, redirect_pc, got.pc);
            end
            if (got.stall[0]) m_stall_cnt = m_stall_cnt + 32'd1;
            if (got.redirect) m_flush_cnt = m_flush_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
        chk({tag, ".bus_err"}, {31'd0, bus_err}, {31'd0, e_berr});
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall_cnt);
        chk({tag, ".flush_cnt"}, flush_cnt, m_flush_cnt);
    endtask

    initial begin
        // Reset values while rst is held
        #2;
        chk("rst.stall", {27'd0, stall}, 32'h00);
        chk("rst.flush", {27'd0, flush}, 32'h1f);
        chk("rst.redirect", {31'd0, redirect}, 32'd0);
        chk("rst.bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst.stall_cnt", stall_cnt, 32'd0);
        chk("rst.flush_cnt", flush_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        step("idle", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // lw x5 in EX, ID reads rs2 = x5
        ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd5;
        id_reg2_re = 1'b1; id_reg2_raddr = 5'd5;
        step("lu_rs2", 5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0);
        ex_is_load = 1'b0; ex_we = 1'b0;
        step("lu_after", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Load into x0 never stalls
        clear_inputs();
        ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd0;
        id_reg1_re = 1'b1; id_reg1_raddr = 5'd0;
        step("lu_x0", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // rs1 address matches but is not read
        ex_waddr = 5'd7; id_reg1_re = 1'b0; id_reg1_raddr = 5'd7;
        id_reg2_re = 1'b1; id_reg2_raddr = 5'd3;
        step("lu_noread", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        id_reg1_re = 1'b1;
        step("lu_rs1", 5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0);

        // Jump beats the hazard
        ex_jump = 1'b1; ex_jump_addr = 32'h0000_0100;
        step("jump_lu", 5'b00000, 5'b00110, 1'b1, 32'h0000_0100, 1'b0);

        // Bus wait with a jump held in EX: taken once, on the ack cycle
        clear_inputs();
        mem_req = 1'b1; ex_jump = 1'b1; ex_jump_addr = 32'h0000_0200;
        step("wait0", 5'b01111, 5'b10000, 1'b0, 32'h0, 1'b0);
        step("wait1", 5'b01111, 5'b10000, 1'b0, 32'h0, 1'b0);
        step("wait2", 5'b01111, 5'b10000, 1'b0, 32'h0, 1'b0);
        mem_ack = 1'b1;
        step("wait_ack", 5'b00000, 5'b00110, 1'b1, 32'h0000_0200, 1'b0);
        clear_inputs();
        step("wait_done", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Request and ack in the same RUN cycle
        mem_req = 1'b1; mem_ack = 1'b1;
        step("req_ack", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Timeout with MEM_TIMEOUT = 4
        mem_ack = 1'b0;
        step("to0", 5'b01111, 5'b10000, 1'b0, 32'h0, 1'b0);
        step("to1", 5'b01111, 5'b10000, 1'b0, 32'h0, 1'b0);
        step("to2", 5'b01111, 5'b10000, 1'b0, 32'h0, 1'b0);
        step("to_rel", 5'b00000, 5'b10000, 1'b0, 32'h0, 1'b1);
        mem_req = 1'b0;
        step("to_run", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        // Async reset in the middle of a wait
        mem_req = 1'b1;
        step("rw_enter", 5'b01111, 5'b10000, 1'b0, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rw.stall", {27'd0, stall}, 32'h00);
        chk("rw.flush", {27'd0, flush}, 32'h1f);
        chk("rw.redirect", {31'd0, redirect}, 32'd0);
        chk("rw.bus_err", {31'd0, bus_err}, 32'd0);
        chk("rw.stall_cnt", stall_cnt, 32'd0);
        chk("rw.flush_cnt", flush_cnt, 32'd0);
        m_stall_cnt = '0;
        m_flush_cnt = '0;
        mem_req = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("rw_after", 5'b00000, 5'b00000, 1'b0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
